// File: rtl/orv64_mem_bp_halt_ctrl_pkg.sv
// Shared types for the memory-breakpoint halt sequencer: virtual address type,
// FSM state encoding and default counter widths.
package orv64_mem_bp_halt_ctrl_pkg;

  localparam int ORV64_VADDR_W = 39;
  typedef logic [ORV64_VADDR_W-1:0] orv64_vaddr_t;

  localparam int HC_CNT_W = 16;
`ifdef ORV64_MEM_BP_SKIP_CNT_EN
  localparam int HC_SKIP_W = 8;
`endif

  typedef enum logic [1:0] {
    HC_IDLE   = 2'd0,
    HC_HALTED = 2'd1,
    HC_RESUME = 2'd2
  } orv64_mem_bp_hc_state_e;

endpackage

// File: rtl/orv64_mem_bp_halt_ctrl_if.sv
// Bundle between the EX->DC breakpoint stage / debug unit and the halt sequencer.
// Skip-count signals exist only when ORV64_MEM_BP_SKIP_CNT_EN is defined.
interface orv64_mem_bp_halt_ctrl_if
  import orv64_mem_bp_halt_ctrl_pkg::*;
#(
  parameter int VADDR_W = $bits(orv64_vaddr_t),
  parameter int CNT_W   = HC_CNT_W
`ifdef ORV64_MEM_BP_SKIP_CNT_EN
  , parameter int SKIP_W = HC_SKIP_W
`endif
);

  logic               mem_bp_stall_in;
  logic [VADDR_W-1:0] ex_addr;
  logic               ex_we;
  logic               ex_flush;
  logic               dc_req_accept;
  logic               dbg_resume_req;
  logic               hit_cnt_clr;

  logic               debug_resume;
  logic               mem_bp_halt_req;
  logic               mem_bp_halted;
  logic [VADDR_W-1:0] hit_addr;
  logic               hit_is_store;
  logic [CNT_W-1:0]   hit_cnt;

`ifdef ORV64_MEM_BP_SKIP_CNT_EN
  logic [SKIP_W-1:0]  skip_cfg;
  logic               skip_cfg_we;
  logic [SKIP_W-1:0]  skip_rem;
`endif

  // Sequencer side.
  modport slave (
    input  mem_bp_stall_in, ex_addr, ex_we, ex_flush, dc_req_accept,
           dbg_resume_req, hit_cnt_clr,
    output debug_resume, mem_bp_halt_req, mem_bp_halted, hit_addr,
           hit_is_store, hit_cnt
`ifdef ORV64_MEM_BP_SKIP_CNT_EN
    , input skip_cfg, skip_cfg_we
    , output skip_rem
`endif
  );

  // Pipeline / debug-unit side.
  modport master (
    output mem_bp_stall_in, ex_addr, ex_we, ex_flush, dc_req_accept,
           dbg_resume_req, hit_cnt_clr,
    input  debug_resume, mem_bp_halt_req, mem_bp_halted, hit_addr,
           hit_is_store, hit_cnt
`ifdef ORV64_MEM_BP_SKIP_CNT_EN
    , output skip_cfg, skip_cfg_we
    , input skip_rem
`endif
  );

endinterface

// File: rtl/orv64_mem_bp_halt_ctrl.sv
// Memory-breakpoint halt sequencer: capture hit, halt (1-cycle latency), hold debug_resume until dcache accepts.
// All outputs registered; ORV64_MEM_BP_SKIP_CNT_EN adds a skip counter that lets N hits pass without halting.
module orv64_mem_bp_halt_ctrl
  import orv64_mem_bp_halt_ctrl_pkg::*;
#(
  parameter int VADDR_W = $bits(orv64_vaddr_t),
  parameter int CNT_W   = HC_CNT_W
`ifdef ORV64_MEM_BP_SKIP_CNT_EN
  , parameter int SKIP_W = HC_SKIP_W
`endif
) (
  input  logic                     clk,
  input  logic                     rstn,
  orv64_mem_bp_halt_ctrl_if.slave  bp_if
);

  orv64_mem_bp_hc_state_e state_q;

  logic               debug_resume_q;
  logic               halt_req_q;
  logic               halted_q;
  logic [VADDR_W-1:0] hit_addr_q;
  logic               hit_is_store_q;
  logic [CNT_W-1:0]   hit_cnt_q;
  logic [CNT_W-1:0]   hit_cnt_d;

  logic hit_vld;
  logic idle_hit;
  logic skip_hit;

  // A flushed request never qualifies as a hit.
  assign hit_vld  = bp_if.mem_bp_stall_in & ~bp_if.ex_flush;
  assign idle_hit = (state_q == HC_IDLE) & hit_vld;

`ifdef ORV64_MEM_BP_SKIP_CNT_EN
  logic [SKIP_W-1:0] skip_rem_q;
  logic [SKIP_W-1:0] skip_rem_d;

  assign skip_hit = idle_hit & (skip_rem_q != '0);

  always_comb begin
    skip_rem_d = skip_rem_q;
    if (bp_if.skip_cfg_we) begin
      skip_rem_d = bp_if.skip_cfg;
    end else if (skip_hit) begin
      skip_rem_d = skip_rem_q - SKIP_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      skip_rem_q <= '0;
    end else begin
      skip_rem_q <= skip_rem_d;
    end
  end

  assign bp_if.skip_rem = skip_rem_q;
`else
  assign skip_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q        <= HC_IDLE;
      debug_resume_q <= 1'b0;
      halt_req_q     <= 1'b0;
      halted_q       <= 1'b0;
      hit_addr_q     <= '0;
      hit_is_store_q <= 1'b0;
    end else begin
      case (state_q)
        HC_IDLE: begin
          // A resume pulse arriving here is dropped; the debug unit resamples halted.
          if (hit_vld) begin
            hit_addr_q     <= bp_if.ex_addr;
            hit_is_store_q <= bp_if.ex_we;
            if (skip_hit) begin
              state_q        <= HC_RESUME;
              debug_resume_q <= 1'b1;
            end else begin
              state_q    <= HC_HALTED;
              halt_req_q <= 1'b1;
              halted_q   <= 1'b1;
            end
          end
        end
        HC_HALTED: begin
          if (bp_if.dbg_resume_req) begin
            state_q        <= HC_RESUME;
            halt_req_q     <= 1'b0;
            halted_q       <= 1'b0;
            debug_resume_q <= 1'b1;
          end
        end
        HC_RESUME: begin
          if (bp_if.dc_req_accept | bp_if.ex_flush) begin
            state_q        <= HC_IDLE;
            debug_resume_q <= 1'b0;
          end
        end
        default: begin
          state_q        <= HC_IDLE;
          debug_resume_q <= 1'b0;
          halt_req_q     <= 1'b0;
          halted_q       <= 1'b0;
        end
      endcase
    end
  end

  // Saturating hit counter; clear wins over a same-cycle increment.
  always_comb begin
    hit_cnt_d = hit_cnt_q;
    if (bp_if.hit_cnt_clr) begin
      hit_cnt_d = '0;
    end else if (idle_hit && (hit_cnt_q != '1)) begin
      hit_cnt_d = hit_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hit_cnt_q <= '0;
    end else begin
      hit_cnt_q <= hit_cnt_d;
    end
  end

  assign bp_if.debug_resume    = debug_resume_q;
  assign bp_if.mem_bp_halt_req = halt_req_q;
  assign bp_if.mem_bp_halted   = halted_q;
  assign bp_if.hit_addr        = hit_addr_q;
  assign bp_if.hit_is_store    = hit_is_store_q;
  assign bp_if.hit_cnt         = hit_cnt_q;

  a_resume_halt_excl: assert property (@(posedge clk) disable iff (!rstn)
    !(debug_resume_q && halt_req_q));
  a_halt_req_eq_halted: assert property (@(posedge clk) disable iff (!rstn)
    halt_req_q == halted_q);

endmodule

// File: tb/tb_orv64_mem_bp_halt_ctrl.sv
// Directed bench: a 16-bit-counter instance plus a 4-bit-counter twin driven in lockstep
// so counter saturation is reachable in a few hundred cycles.
module tb_orv64_mem_bp_halt_ctrl;
  import orv64_mem_bp_halt_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rstn;
  int   n_run  = 0;
  int   n_fail = 0;
  int   dr_cycles;

  always #5 clk = ~clk;

  orv64_mem_bp_halt_ctrl_if #(.CNT_W(16)) m_if ();
  orv64_mem_bp_halt_ctrl_if #(.CNT_W(4))  s_if ();

  assign s_if.mem_bp_stall_in = m_if.mem_bp_stall_in;
  assign s_if.ex_addr         = m_if.ex_addr;
  assign s_if.ex_we           = m_if.ex_we;
  assign s_if.ex_flush        = m_if.ex_flush;
  assign s_if.dc_req_accept   = m_if.dc_req_accept;
  assign s_if.dbg_resume_req  = m_if.dbg_resume_req;
  assign s_if.hit_cnt_clr     = m_if.hit_cnt_clr;
`ifdef ORV64_MEM_BP_SKIP_CNT_EN
  assign s_if.skip_cfg        = m_if.skip_cfg;
  assign s_if.skip_cfg_we     = m_if.skip_cfg_we;
`endif

  orv64_mem_bp_halt_ctrl #(.CNT_W(16)) u_dut (
    .clk   (clk),
    .rstn  (rstn),
    .bp_if (m_if.slave)
  );

  orv64_mem_bp_halt_ctrl #(.CNT_W(4)) u_dut_small (
    .clk   (clk),
    .rstn  (rstn),
    .bp_if (s_if.slave)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m_if.mem_bp_stall_in = 1'b0;
    m_if.ex_addr         = '0;
    m_if.ex_we           = 1'b0;
    m_if.ex_flush        = 1'b0;
    m_if.dc_req_accept   = 1'b0;
    m_if.dbg_resume_req  = 1'b0;
    m_if.hit_cnt_clr     = 1'b0;
`ifdef ORV64_MEM_BP_SKIP_CNT_EN
    m_if.skip_cfg        = '0;
    m_if.skip_cfg_we     = 1'b0;
`endif
  endtask

  task automatic do_hit(input orv64_vaddr_t a, input logic w);
    m_if.mem_bp_stall_in = 1'b1;
    m_if.ex_addr         = a;
    m_if.ex_we           = w;
    tick();
    m_if.mem_bp_stall_in = 1'b0;
    m_if.ex_we           = 1'b0;
  endtask

  task automatic release_from_halt();
    m_if.dbg_resume_req = 1'b1;
    tick();
    m_if.dbg_resume_req = 1'b0;
    m_if.dc_req_accept  = 1'b1;
    tick();
    m_if.dc_req_accept  = 1'b0;
  endtask

  initial begin
    rstn = 1'b0;
    idle_inputs();
    #12;
    check("rst_halt_req", m_if.mem_bp_halt_req, 0);
    check("rst_halted", m_if.mem_bp_halted, 0);
    check("rst_debug_resume", m_if.debug_resume, 0);
    check("rst_hit_addr", m_if.hit_addr, 0);
    check("rst_hit_is_store", m_if.hit_is_store, 0);
    check("rst_hit_cnt", m_if.hit_cnt, 0);
`ifdef ORV64_MEM_BP_SKIP_CNT_EN
    check("rst_skip_rem", m_if.skip_rem, 0);
`endif
    rstn = 1'b1;
    tick();

    // Store hit halts one cycle later with address/type captured.
    do_hit(39'h0_8000_1000, 1'b1);
    check("hit_halt_req", m_if.mem_bp_halt_req, 1);
    check("hit_halted", m_if.mem_bp_halted, 1);
    check("hit_debug_resume", m_if.debug_resume, 0);
    check("hit_addr", m_if.hit_addr, 64'h8000_1000);
    check("hit_is_store", m_if.hit_is_store, 1);
    check("hit_cnt_1", m_if.hit_cnt, 1);
    check("hit_cnt_1_small", s_if.hit_cnt, 1);

    // Resume; accept arrives in the 4th debug_resume cycle.
    m_if.dbg_resume_req = 1'b1;
    tick();
    m_if.dbg_resume_req = 1'b0;
    check("resume_halt_req", m_if.mem_bp_halt_req, 0);
    check("resume_halted", m_if.mem_bp_halted, 0);
    dr_cycles = 0;
    for (int i = 0; i < 8; i++) begin
      if (m_if.debug_resume) dr_cycles++;
      m_if.dc_req_accept = (i == 3);
      tick();
    end
    m_if.dc_req_accept = 1'b0;
    check("resume_width", dr_cycles, 4);
    check("resume_done_dr", m_if.debug_resume, 0);

    // Second hit with a coincident resume pulse: pulse dropped, stays halted.
    m_if.dbg_resume_req = 1'b1;
    do_hit(39'h1234, 1'b0);
    m_if.dbg_resume_req = 1'b0;
    check("hit2_halted", m_if.mem_bp_halted, 1);
    check("hit2_cnt", m_if.hit_cnt, 2);
    check("hit2_is_store", m_if.hit_is_store, 0);
    check("hit2_addr", m_if.hit_addr, 64'h1234);
    tick();
    check("hit2_resume_dropped", m_if.mem_bp_halted, 1);
    m_if.ex_flush = 1'b1;
    tick();
    m_if.ex_flush = 1'b0;
    check("flush_in_halted", m_if.mem_bp_halted, 1);

    // Flush terminates RESUME.
    m_if.dbg_resume_req = 1'b1;
    tick();
    m_if.dbg_resume_req = 1'b0;
    check("resume2_dr", m_if.debug_resume, 1);
    m_if.ex_flush = 1'b1;
    tick();
    m_if.ex_flush = 1'b0;
    check("resume_flush_dr", m_if.debug_resume, 0);
    check("resume_flush_halted", m_if.mem_bp_halted, 0);

    // Flush beats a match in IDLE.
    m_if.ex_flush = 1'b1;
    do_hit(39'hDEAD, 1'b1);
    m_if.ex_flush = 1'b0;
    check("idle_flush_halted", m_if.mem_bp_halted, 0);
    check("idle_flush_cnt", m_if.hit_cnt, 2);
    check("idle_flush_addr", m_if.hit_addr, 64'h1234);

    // Matching access right after resume is re-evaluated in IDLE and halts again.
    do_hit(39'h40, 1'b1);
    m_if.dbg_resume_req = 1'b1;
    tick();
    m_if.dbg_resume_req  = 1'b0;
    m_if.mem_bp_stall_in = 1'b1;
    m_if.ex_addr         = 39'h48;
    m_if.dc_req_accept   = 1'b1;
    tick();
    m_if.dc_req_accept   = 1'b0;
    tick();
    m_if.mem_bp_stall_in = 1'b0;
    check("rematch_halted", m_if.mem_bp_halted, 1);
    check("rematch_addr", m_if.hit_addr, 64'h48);
    check("rematch_cnt", m_if.hit_cnt, 4);
    release_from_halt();

    // 13 more hits: 17 total, 4-bit twin pinned at 0xF.
    for (int i = 0; i < 13; i++) begin
      do_hit(orv64_vaddr_t'(i), 1'b0);
      release_from_halt();
    end
    check("sat_cnt_wide", m_if.hit_cnt, 17);
    check("sat_cnt_small", s_if.hit_cnt, 4'hF);

    // Clear coincident with a hit: result 0, hit still captured and halts.
    m_if.hit_cnt_clr = 1'b1;
    do_hit(39'h99, 1'b0);
    m_if.hit_cnt_clr = 1'b0;
    check("clr_cnt_wide", m_if.hit_cnt, 0);
    check("clr_cnt_small", s_if.hit_cnt, 0);
    check("clr_halted", m_if.mem_bp_halted, 1);
    check("clr_addr", m_if.hit_addr, 64'h99);

    // Asynchronous reset mid-cycle while halted.
    #3;
    rstn = 1'b0;
    #1;
    check("arst_halt_req", m_if.mem_bp_halt_req, 0);
    check("arst_halted", m_if.mem_bp_halted, 0);
    check("arst_addr", m_if.hit_addr, 0);
    check("arst_cnt", m_if.hit_cnt, 0);
    #2;
    rstn = 1'b1;
    tick();
    check("arst_idle", m_if.mem_bp_halted, 0);
    do_hit(39'h0_8000_1000, 1'b1);
    check("arst_rehit_halted", m_if.mem_bp_halted, 1);
    check("arst_rehit_cnt", m_if.hit_cnt, 1);
    release_from_halt();

`ifdef ORV64_MEM_BP_SKIP_CNT_EN
    m_if.skip_cfg    = 8'd2;
    m_if.skip_cfg_we = 1'b1;
    tick();
    m_if.skip_cfg_we = 1'b0;
    check("skip_load", m_if.skip_rem, 2);
    for (int i = 0; i < 2; i++) begin
      do_hit(39'h500, 1'b1);
      check("skip_dr", m_if.debug_resume, 1);
      check("skip_halt_req", m_if.mem_bp_halt_req, 0);
      check("skip_rem", m_if.skip_rem, 64'(1 - i));
      m_if.dc_req_accept = 1'b1;
      tick();
      m_if.dc_req_accept = 1'b0;
    end
    check("skip_cnt", m_if.hit_cnt, 3);
    do_hit(39'h508, 1'b0);
    check("skip_third_halts", m_if.mem_bp_halt_req, 1);
    check("skip_third_rem", m_if.skip_rem, 0);
    release_from_halt();
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
